mips_cpu_bus_master: RTL and testbench

Avalon-style bus initiator that sits between the MIPS CPU core's load/store/fetch logic and the memory bus. It accepts one request at a time from the core and issues a single word-aligned read or write with the correct byteenable lanes. It stalls on `waitrequest`, then returns load data to the core after lane extraction and sign or zero extension. Misaligned accesses are rejected without any bus activity.

---
 rtl/mips_cpu_bus_master.sv | 153 +++++++++++++++
 tb/tb_mips_cpu_bus_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_bus_master.sv
// Avalon-style bus initiator for the MIPS core: one word-aligned read or write per request,
// with byte-lane steering on stores and lane extraction plus sign/zero extension on loads.
module mips_cpu_bus_master #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [31:0]       writedata,
  input  logic              waitrequest,
  input  logic [31:0]       readdata
);

  typedef enum logic [1:0] {IDLE, BUS, RD_WAIT, RESP} state_t;

  state_t      state;
  logic        is_write;
  logic [1:0]  lane;
  logic [1:0]  size;
  logic        sign;

  logic        legal;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // Legality, lane enables and replicated store data are decoded straight from the request.
  always_comb begin
    legal      = 1'b0;
    be_next    = 4'b1111;
    wdata_next = req_wdata;
    case (req_size)
      2'b00: begin
        legal      = 1'b1;
        be_next    = 4'b0001 << req_addr[1:0];
        wdata_next = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        legal      = ~req_addr[0];
        be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        legal      = (req_addr[1:0] == 2'b00);
      end
      default: begin
        legal      = 1'b0;
      end
    endcase
  end

  always_comb begin
    byte_sel  = readdata[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? readdata[31:16] : readdata[15:0];
    load_data = readdata;
    case (size)
      2'b00:   load_data = sign ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      2'b01:   load_data = sign ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      default: load_data = readdata;
    endcase
  end

  // req_ready comes up one cycle after reset so a request is never accepted in the reset cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= 32'd0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      byteenable <= 4'd0;
      writedata  <= 32'd0;
      is_write   <= 1'b0;
      lane       <= 2'd0;
      size       <= 2'd0;
      sign       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            req_ready <= 1'b0;
            is_write  <= req_write;
            lane      <= req_addr[1:0];
            size      <= req_size;
            sign      <= req_signed;
            if (legal) begin
              state      <= BUS;
              address    <= {req_addr[ADDR_W-1:2], 2'b00};
              byteenable <= be_next;
              writedata  <= wdata_next;
              read       <= ~req_write;
              write      <= req_write;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            if (is_write) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= 32'd0;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= load_data;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// Bench for mips_cpu_bus_master: a byte-array bus slave plus a request-level reference
// model that predicts every load result from store/load semantics alone.
module tb_mips_cpu_bus_master;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  mips_cpu_bus_master #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  int wait_mode = 0;
  int forced_n = 0;
  int wait_cycles = 0;
  int strobe_cycles = 0;
  logic [31:0] last_addr = 0;
  logic [3:0]  last_be = 0;
  logic [31:0] last_wdata = 0;

  int got_lat;
  logic got_err;
  logic [31:0] got_rdata;
  logic after_valid;
  logic after_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input int a, input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    if (sz == 2'b00) v = sg ? 32'(signed'(ref_mem[a])) : 32'(ref_mem[a]);
    else if (sz == 2'b01) v = sg ? 32'(signed'({ref_mem[a+1], ref_mem[a]}))
                                 : 32'({ref_mem[a+1], ref_mem[a]});
    else v = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    return v;
  endfunction

  task automatic model_store(input int a, input logic [1:0] sz, input logic [31:0] wd);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int k = 0; k < n; k++) ref_mem[a+k] = wd[8*k +: 8];
  endtask

  function automatic bit is_legal(input int a, input logic [1:0] sz);
    if (sz == 2'b00) return 1'b1;
    if (sz == 2'b01) return (a % 2) == 0;
    if (sz == 2'b10) return (a % 4) == 0;
    return 1'b0;
  endfunction

  // Bus slave: handshakes are judged at the falling edge, responses driven just after the rising edge.
  initial begin : slave
    logic        rd_pending;
    int          rd_base;
    int          wait_used;
    logic        prev_hold;
    logic [69:0] hold_snap;
    rd_pending = 1'b0; rd_base = 0; wait_used = 0; prev_hold = 1'b0; hold_snap = '0;
    waitrequest = 1'b0;
    readdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_pending) readdata = {mem[rd_base+3], mem[rd_base+2], mem[rd_base+1], mem[rd_base]};
      else readdata = $urandom;
      rd_pending = 1'b0;
      case (wait_mode)
        0: waitrequest = 1'b0;
        1: waitrequest = ($urandom_range(0, 99) < 20);
        2: begin
          if (read || write) begin
            if (wait_used < forced_n) begin waitrequest = 1'b1; wait_used++; end
            else waitrequest = 1'b0;
          end else begin
            waitrequest = 1'b0;
            wait_used = 0;
          end
        end
        default: waitrequest = 1'b1;
      endcase
      @(negedge clk);
      if (!reset) begin
        if (prev_hold) begin
          compared++;
          assert ({read, write, address, byteenable, writedata} === hold_snap) else begin
            mismatched++;
            $error("[TB] FAIL bus_hold: observed=%h expected=%h",
                   {read, write, address, byteenable, writedata}, hold_snap);
          end
        end
        if (read || write) begin
          checkOutput("one_strobe", {31'd0, read & write}, 32'd0);
          strobe_cycles++;
          if (waitrequest) begin
            wait_cycles++;
          end else begin
            last_addr = address;
            last_be = byteenable;
            last_wdata = writedata;
            if (read) begin
              rd_pending = 1'b1;
              rd_base = int'(address[7:0]);
            end else begin
              for (int k = 0; k < 4; k++)
                if (byteenable[k]) mem[int'(address[7:0]) + k] = writedata[8*k +: 8];
            end
          end
        end
      end
      prev_hold = !reset && (read || write) && waitrequest;
      hold_snap = {read, write, address, byteenable, writedata};
    end
  end

  // Presents one request, waits for its response and records what came back.
  task automatic applyStimulus(input logic wr, input int a, input logic [1:0] sz,
                               input logic sg, input logic [31:0] wd);
    int n;
    int acc;
    bit got;
    @(negedge clk);
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) checkOutput("ready_timeout", 32'd0, 32'd1);
    wait_cycles = 0;
    strobe_cycles = 0;
    req_valid = 1'b1; req_write = wr; req_addr = 32'(a);
    req_size = sz; req_signed = sg; req_wdata = wd;
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
    req_wdata = $urandom;
    got = 1'b0; n = 0; got_lat = -1;
    while (!got && n < 100) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        got_lat = cyc - acc + 1;
        got_err = rsp_err;
        got_rdata = rsp_rdata;
      end
      n++;
    end
    if (!got) checkOutput("rsp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    after_valid = rsp_valid;
    after_ready = req_ready;
  endtask

  task automatic checkResponse(input string tag, input logic exp_err,
                               input logic [31:0] exp_data, input int exp_lat);
    checkOutput({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
    checkOutput({tag, "_rdata"}, got_rdata, exp_data);
    checkOutput({tag, "_latency"}, 32'(got_lat), 32'(exp_lat));
    checkOutput({tag, "_pulse_end"}, {31'd0, after_valid}, 32'd0);
    checkOutput({tag, "_ready_again"}, {31'd0, after_ready}, 32'd1);
  endtask

  initial begin : stimulus
    logic rsp_seen;
    logic wr, sg;
    logic [1:0] sz;
    int a;
    logic [31:0] wd;
    logic [31:0] expv;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    req_size = 2'b00; req_signed = 1'b0; req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16] = 8'h44; mem[17] = 8'h33; mem[18] = 8'h22; mem[19] = 8'h11;
    for (int i = 16; i < 20; i++) ref_mem[i] = mem[i];

    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_rsp", {29'd0, rsp_valid, rsp_err, read | write}, 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_address", address, 32'd0);
    checkOutput("rst_byteenable", {28'd0, byteenable}, 32'd0);
    checkOutput("rst_writedata", writedata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {31'd0, req_ready}, 32'd1);

    $display("[TB] zero-wait word load");
    applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'd0);
    checkResponse("lw", 1'b0, 32'h1122_3344, 3);
    checkOutput("lw_strobe_cycles", 32'(strobe_cycles), 32'd1);
    checkOutput("lw_be", {28'd0, last_be}, 32'hF);
    checkOutput("lw_addr", last_addr, 32'h10);

    $display("[TB] byte loads with three forced waits");
    mem[19] = 8'h80; ref_mem[19] = 8'h80;
    wait_mode = 2; forced_n = 3;
    applyStimulus(1'b0, 32'h13, 2'b00, 1'b1, 32'd0);
    checkResponse("lb", 1'b0, 32'hFFFF_FF80, 6);
    checkOutput("lb_strobe_cycles", 32'(strobe_cycles), 32'd4);
    checkOutput("lb_be", {28'd0, last_be}, 32'h8);
    applyStimulus(1'b0, 32'h13, 2'b00, 1'b0, 32'd0);
    checkResponse("lbu", 1'b0, 32'h0000_0080, 6);
    wait_mode = 0;

    $display("[TB] half store then word load");
    applyStimulus(1'b1, 32'h22, 2'b01, 1'b0, 32'h1234_BEEF);
    model_store(32'h22, 2'b01, 32'h1234_BEEF);
    checkResponse("sh", 1'b0, 32'd0, 2);
    checkOutput("sh_addr", last_addr, 32'h20);
    checkOutput("sh_be", {28'd0, last_be}, 32'hC);
    checkOutput("sh_wdata", last_wdata, 32'hBEEF_BEEF);
    applyStimulus(1'b0, 32'h20, 2'b10, 1'b0, 32'd0);
    checkResponse("lw_after_sh", 1'b0, model_load(32'h20, 2'b10, 1'b0), 3);
    checkOutput("lw_after_sh_hi", {16'd0, got_rdata[31:16]}, 32'h0000_BEEF);

    $display("[TB] rejected requests");
    applyStimulus(1'b0, 32'h06, 2'b10, 1'b0, 32'd0);
    checkResponse("err_word", 1'b1, 32'd0, 1);
    checkOutput("err_word_strobes", 32'(strobe_cycles), 32'd0);
    applyStimulus(1'b0, 32'h03, 2'b01, 1'b1, 32'd0);
    checkResponse("err_half", 1'b1, 32'd0, 1);
    checkOutput("err_half_strobes", 32'(strobe_cycles), 32'd0);
    applyStimulus(1'b1, 32'h08, 2'b11, 1'b0, 32'hDEAD_BEEF);
    checkResponse("err_size", 1'b1, 32'd0, 1);
    checkOutput("err_size_strobes", 32'(strobe_cycles), 32'd0);

    $display("[TB] reset during a stalled read");
    wait_mode = 3;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_signed = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_read_high", {31'd0, read}, 32'd1);
    reset = 1'b1;
    rsp_seen = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_read_low", {31'd0, read}, 32'd0);
    checkOutput("rst_mid_ready_low", {31'd0, req_ready}, 32'd0);
    rsp_seen = rsp_valid;
    reset = 1'b0;
    wait_mode = 0;
    @(negedge clk);
    checkOutput("rst_mid_ready_back", {31'd0, req_ready}, 32'd1);
    rsp_seen = rsp_seen | rsp_valid;
    repeat (3) begin
      @(negedge clk);
      rsp_seen = rsp_seen | rsp_valid;
    end
    checkOutput("rst_mid_no_rsp", {31'd0, rsp_seen}, 32'd0);
    applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'd0);
    checkResponse("lw_after_rst", 1'b0, model_load(32'h10, 2'b10, 1'b0), 3);

    $display("[TB] randomized traffic");
    wait_mode = 1;
    for (int t = 0; t < 60; t++) begin
      wr = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 9) != 0) begin
        if (sz == 2'b01) a = a & ~1;
        if (sz == 2'b10) a = a & ~3;
      end
      wd = $urandom;
      applyStimulus(wr, a, sz, sg, wd);
      if (!is_legal(a, sz)) begin
        checkResponse("rnd_err", 1'b1, 32'd0, 1);
        checkOutput("rnd_err_strobes", 32'(strobe_cycles), 32'd0);
      end else if (wr) begin
        model_store(a, sz, wd);
        checkResponse("rnd_store", 1'b0, 32'd0, 2 + wait_cycles);
      end else begin
        expv = model_load(a, sz, sg);
        checkResponse("rnd_load", 1'b0, expv, 3 + wait_cycles);
      end
    end
    wait_mode = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i += 4)
      checkOutput("final_mem", {mem[i+3], mem[i+2], mem[i+1], mem[i]},
                  {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
